display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 55 +++++
 tb/tb_display_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: time-multiplexes two 7-segment digits with dead-time blanking,
// per-frame pulse and alarm-driven blinking.
module display_scan #(
  parameter int DIV        = 50000,
  parameter int BLANK      = 1000,
  parameter int BLINK_LOG2 = 4
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [6:0] SegCaixa,
  input  logic [6:0] SegAcio,
  input  logic       Alarme,
  output logic       ChaveSeletora,
  output logic [1:0] Anodo,
  output logic [6:0] Segmentos,
  output logic       FrameTick
);
  typedef enum logic [1:0] {BLANK_C, SHOW_C, BLANK_A, SHOW_A} state_t;
  state_t      state, stateNext;
  logic [15:0] phase;
  logic [7:0]  frameCnt;
  logic        alarmLatched, done, leaving, blink;
  logic [1:0]  anodoNext;
  logic [6:0]  segNext;
  always_comb begin
    done      = phase == ((state == SHOW_C || state == SHOW_A) ? 16'(DIV - 1) : 16'(BLANK - 1));
    stateNext = done ? state_t'(state + 2'd1) : state;
    leaving   = done && state == SHOW_A;
    blink     = alarmLatched && frameCnt[BLINK_LOG2];
    // Segments only change on state entry, so mid-show input changes are ignored.
    segNext   = !done ? Segmentos : stateNext == SHOW_C ? SegCaixa : stateNext == SHOW_A ? SegAcio : 7'h00;
    anodoNext = blink ? 2'b11 : stateNext == SHOW_C ? 2'b10 : stateNext == SHOW_A ? 2'b01 : 2'b11;
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= BLANK_C;
      phase         <= '0;
      frameCnt      <= '0;
      alarmLatched  <= 1'b0;
      ChaveSeletora <= 1'b0;
      Anodo         <= 2'b11;
      Segmentos     <= 7'h00;
      FrameTick     <= 1'b0;
    end else begin
      state         <= stateNext;
      phase         <= done ? '0 : phase + 16'd1;
      frameCnt      <= frameCnt + 8'(leaving);
      alarmLatched  <= leaving ? Alarme : alarmLatched;
      ChaveSeletora <= stateNext[1];
      Anodo         <= anodoNext;
      Segmentos     <= segNext;
      FrameTick     <= leaving;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan with DIV=4, BLANK=2, BLINK_LOG2=1
// (12-cycle frames: blank 0-1, tank 2-5, blank 6-7, irrigation 8-11).
module tb_display_scan;
  logic       Clock = 1'b0, Reset_n = 1'b0, Alarme = 1'b0;
  logic [6:0] SegCaixa = 7'h3F, SegAcio = 7'h06;
  logic       ChaveSeletora, FrameTick;
  logic [1:0] Anodo;
  logic [6:0] Segmentos;
  int         checks = 0, errors = 0;
  logic [10:0] q[$];
  int         mCyc;
  logic [7:0] mFrame;
  logic       mAlarm;
  logic [6:0] mSeg;

  display_scan #(.DIV(4), .BLANK(2), .BLINK_LOG2(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .SegCaixa(SegCaixa), .SegAcio(SegAcio),
    .Alarme(Alarme), .ChaveSeletora(ChaveSeletora), .Anodo(Anodo),
    .Segmentos(Segmentos), .FrameTick(FrameTick)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    logic [10:0] expv, got;
    #1;
    if (q.size() > 0) begin
      expv = q.pop_front();
      got  = {ChaveSeletora, Anodo, Segmentos, FrameTick};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL cycle%0d frame%0d got sel=%b an=%b seg=%h tick=%b want sel=%b an=%b seg=%h tick=%b",
                 mCyc, mFrame, got[10], got[9:8], got[7:1], got[0], expv[10], expv[9:8], expv[7:1], expv[0]);
      end
    end
  end

  task automatic resetModel();
    mCyc = 0; mFrame = 0; mAlarm = 0; mSeg = 0;
    q.delete();
  endtask

  // Predict outputs for the next cycle from the inputs present at this edge, then advance.
  task automatic cycle();
    int n;
    logic tick, bl;
    logic [1:0] an;
    n = (mCyc + 1) % 12;
    tick = (n == 0);
    if (tick) begin mFrame++; mAlarm = Alarme; end
    bl = mAlarm && mFrame[1];
    if (n == 2) mSeg = SegCaixa;
    else if (n == 8) mSeg = SegAcio;
    else if (!(n inside {[3:5], [9:11]})) mSeg = 7'h00;
    an = (n inside {[2:5]}) ? (bl ? 2'b11 : 2'b10) : (n inside {[8:11]}) ? (bl ? 2'b11 : 2'b01) : 2'b11;
    q.push_back({n >= 6, an, mSeg, tick});
    mCyc = n;
    @(posedge Clock);
    #2;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    resetModel();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #23;
    checks++;
    if ({ChaveSeletora, Anodo, Segmentos, FrameTick} !== {1'b0, 2'b11, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset got sel=%b an=%b seg=%h tick=%b want 0 11 00 0", ChaveSeletora, Anodo, Segmentos, FrameTick);
    end
  endtask

  task automatic test_normal_frame();
    SegCaixa = 7'h3F; SegAcio = 7'h06; Alarme = 1'b0;
    doReset();
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (i == 3) begin
        checks++;
        if (Anodo !== 2'b10 || Segmentos !== 7'h3F) begin
          errors++;
          $display("FAIL normal_tank got an=%b seg=%h want 10 3f", Anodo, Segmentos);
        end
      end
      if (i == 9) begin
        checks++;
        if (Anodo !== 2'b01 || Segmentos !== 7'h06 || ChaveSeletora !== 1'b1) begin
          errors++;
          $display("FAIL normal_irr got an=%b seg=%h sel=%b want 01 06 1", Anodo, Segmentos, ChaveSeletora);
        end
      end
    end
    checks++;
    if (FrameTick !== 1'b1) begin
      errors++;
      $display("FAIL normal_tick got %b want 1", FrameTick);
    end
  endtask

  task automatic test_mid_show_change();
    SegCaixa = 7'h3F; SegAcio = 7'h06; Alarme = 1'b0;
    doReset();
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (i == 3) SegCaixa = 7'h5B;
      if (i == 5) begin
        checks++;
        if (Segmentos !== 7'h3F) begin
          errors++;
          $display("FAIL midshow_hold got %h want 3f", Segmentos);
        end
      end
    end
    checks++;
    if (Segmentos !== 7'h5B) begin
      errors++;
      $display("FAIL midshow_next got %h want 5b", Segmentos);
    end
  endtask

  task automatic test_alarm_blink();
    SegCaixa = 7'h3F; SegAcio = 7'h06; Alarme = 1'b1;
    doReset();
    for (int i = 1; i <= 96; i++) begin
      cycle();
      if (i % 12 == 3) begin
        checks++;
        if (Anodo !== ((((i / 12) % 4) >= 2) ? 2'b11 : 2'b10)) begin
          errors++;
          $display("FAIL blink frame%0d got an=%b", i / 12, Anodo);
        end
      end
    end
    Alarme = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    SegCaixa = 7'h3F; SegAcio = 7'h06; Alarme = 1'b0;
    doReset();
    for (int i = 1; i <= 9; i++) cycle();
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Anodo !== 2'b11 || Segmentos !== 7'h00 || ChaveSeletora !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got an=%b seg=%h sel=%b want 11 00 0", Anodo, Segmentos, ChaveSeletora);
    end
    doReset();
    for (int i = 1; i <= 13; i++) cycle();
  endtask

  task automatic test_frame_wrap();
    int ticks;
    ticks = 0;
    SegCaixa = 7'h77; SegAcio = 7'h1C; Alarme = 1'b1;
    doReset();
    for (int i = 1; i <= 256 * 12 + 36; i++) begin
      cycle();
      if (i <= 256 * 12 && FrameTick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 256) begin
      errors++;
      $display("FAIL wrap_ticks got %0d want 256", ticks);
    end
    Alarme = 1'b0;
  endtask

  initial begin
    resetModel();
    test_reset();
    test_normal_frame();
    test_mid_show_change();
    test_alarm_blink();
    test_reset_mid_frame();
    test_frame_wrap();
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
